// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution datapath: default operand and
// accumulator widths, a constant clog2 and the saturating output slice.
package cnn_pkg;

    localparam int A_WIDTH       = 16;
    localparam int B_WIDTH       = 16;
    localparam int ACC_WIDTH     = 40;
    localparam int SLICE_MAX_ACC = 128;
    localparam int SLICE_MAX_OUT = 64;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // x holds an acc_width-bit accumulator in its low bits; the upper bits are ignored.
    function automatic logic [SLICE_MAX_OUT-1:0] sat_slice(
        input logic [SLICE_MAX_ACC-1:0] x,
        input int                       acc_width,
        input int                       out_shift,
        input int                       out_width,
        input logic                     saturate
    );
        logic signed [SLICE_MAX_ACC-1:0] x_ext;
        logic signed [SLICE_MAX_ACC-1:0] shifted;
        logic signed [SLICE_MAX_ACC-1:0] upper;
        logic        [SLICE_MAX_OUT-1:0] mask;
        logic        [SLICE_MAX_OUT-1:0] trunc;
        x_ext   = $signed(x << (SLICE_MAX_ACC - acc_width)) >>> (SLICE_MAX_ACC - acc_width);
        shifted = x_ext >>> out_shift;
        upper   = shifted >>> (out_width - 1);
        mask    = (SLICE_MAX_OUT'(1'b1) << out_width) - SLICE_MAX_OUT'(1'b1);
        trunc   = shifted[SLICE_MAX_OUT-1:0] & mask;
        if (!saturate || upper == '0 || upper == '1) begin
            return trunc;
        end else if (x_ext[SLICE_MAX_ACC-1]) begin
            return SLICE_MAX_OUT'(1'b1) << (out_width - 1);
        end else begin
            return mask >> 1;
        end
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed MAC lane: product, window-start base select, accumulator and
// the sliced (optionally saturated) view of the running sum.
module mac_lane
    import cnn_pkg::*;
#(
    parameter int A_WIDTH   = cnn_pkg::A_WIDTH,
    parameter int B_WIDTH   = cnn_pkg::B_WIDTH,
    parameter int ACC_WIDTH = cnn_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SHIFT = 16,
    parameter int SATURATE  = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 fire,
    input  logic                 restart,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic [OUT_WIDTH-1:0] result
);

    localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod_s;
    logic signed [ACC_WIDTH-1:0]  base_s;
    logic signed [ACC_WIDTH-1:0]  sum_s;
    logic signed [ACC_WIDTH-1:0]  acc_r;

    // Product, base select and the sliced sum presented to the output register.
    always_comb begin
        prod_s = PROD_WIDTH'($signed(a)) * PROD_WIDTH'($signed(b));
        if (restart) begin
            base_s = '0;
        end else begin
            base_s = acc_r;
        end
        sum_s  = base_s + ACC_WIDTH'(prod_s);
        result = OUT_WIDTH'(sat_slice(SLICE_MAX_ACC'($unsigned(sum_s)), ACC_WIDTH,
                                      OUT_SHIFT, OUT_WIDTH, SATURATE != 0));
    end

    // Accumulator; the value left after a final beat is never read back.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= '0;
        end else if (fire) begin
            acc_r <= sum_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/mac_array.sv
// Multi-lane windowed MAC engine: shared beat handshake and window counter,
// LANES mac_lane instances and a registered valid/ready result stage.
module mac_array
    import cnn_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int A_WIDTH    = cnn_pkg::A_WIDTH,
    parameter int B_WIDTH    = cnn_pkg::B_WIDTH,
    parameter int ACC_WIDTH  = cnn_pkg::ACC_WIDTH,
    parameter int KERNEL_LEN = 9,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_SHIFT  = 16,
    parameter int SATURATE   = 1,
    parameter int CNT_WIDTH  = clog2(KERNEL_LEN + 1)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*A_WIDTH-1:0]   a,
    input  logic [LANES*B_WIDTH-1:0]   b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*OUT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]       beat_count
);

    logic                       fire_s;
    logic                       restart_s;
    logic                       final_s;
    logic [OUT_WIDTH-1:0]       lane_result_s [LANES];
    logic [CNT_WIDTH-1:0]       beat_count_r;
    logic                       out_valid_r;
    logic [LANES*OUT_WIDTH-1:0] out_data_r;

    // Handshake and window-position decode; clear restarts the window.
    always_comb begin
        in_ready  = !(out_valid_r && !out_ready);
        fire_s    = in_valid && in_ready;
        restart_s = (beat_count_r == '0) || clear;
        if (KERNEL_LEN == 1) begin
            final_s = fire_s;
        end else begin
            final_s = fire_s && !clear && (beat_count_r == CNT_WIDTH'(KERNEL_LEN - 1));
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .A_WIDTH  (A_WIDTH),
            .B_WIDTH  (B_WIDTH),
            .ACC_WIDTH(ACC_WIDTH),
            .OUT_WIDTH(OUT_WIDTH),
            .OUT_SHIFT(OUT_SHIFT),
            .SATURATE (SATURATE)
        ) u_lane (
            .clock  (clock),
            .reset_n(reset_n),
            .fire   (fire_s),
            .restart(restart_s),
            .a      (a[i*A_WIDTH +: A_WIDTH]),
            .b      (b[i*B_WIDTH +: B_WIDTH]),
            .result (lane_result_s[i])
        );
    end

    // Window beat counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_count_r <= '0;
        end else if (final_s) begin
            beat_count_r <= '0;
        end else if (clear) begin
            beat_count_r <= fire_s ? CNT_WIDTH'(1'b1) : '0;
        end else if (fire_s) begin
            beat_count_r <= beat_count_r + CNT_WIDTH'(1'b1);
        end else begin
            beat_count_r <= beat_count_r;
        end
    end

    // Result register; a new final beat may reload it in the cycle it is taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (final_s) begin
            out_valid_r <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
                out_data_r[i*OUT_WIDTH +: OUT_WIDTH] <= lane_result_s[i];
            end
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign beat_count = beat_count_r;

endmodule

// File: tb/tb_mac_array.sv
// Directed bench for mac_array with two lanes and a 3-beat window; a second
// instance with SATURATE=0 shares the stimulus for the truncation cases.
module tb_mac_array;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_ready_s;
    logic        out_valid_s;
    logic [31:0] out_data_s;
    logic [1:0]  beat_count_s;
    logic        in_ready_t;
    logic        out_valid_t;
    logic [31:0] out_data_t;
    logic [1:0]  beat_count_t;
    int          check_count = 0;
    int          error_count = 0;

    always #5 clock = ~clock;

    mac_array #(.LANES(2), .KERNEL_LEN(3), .SATURATE(1)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready_s), .a(a), .b(b), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .beat_count(beat_count_s)
    );

    mac_array #(.LANES(2), .KERNEL_LEN(3), .SATURATE(0)) dut_trunc (
        .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready_t), .a(a), .b(b), .out_valid(out_valid_t),
        .out_ready(out_ready), .out_data(out_data_t), .beat_count(beat_count_t)
    );

    task automatic check_value(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1);
        a = {a1, a0};
        b = {b1, b0};
    endtask

    task automatic beat(input logic [15:0] a0, input logic [15:0] b0,
                        input logic [15:0] a1, input logic [15:0] b1);
        set_ops(a0, b0, a1, b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_ops(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        step();
        step();
        check_value("rst_out_valid", 64'(out_valid_s), 64'd0);
        check_value("rst_out_data", 64'(out_data_s), 64'd0);
        check_value("rst_beat_count", 64'(beat_count_s), 64'd0);
        reset_n = 1'b1;
        step();
        check_value("rst_in_ready", 64'(in_ready_s), 64'd1);

        // basic window
        beat(16'h4000, 16'h4000, 16'hFFFF, 16'h0001);
        check_value("basic_bc1", 64'(beat_count_s), 64'd1);
        check_value("basic_ov_b1", 64'(out_valid_s), 64'd0);
        beat(16'h4000, 16'h4000, 16'hFFFF, 16'h0001);
        check_value("basic_bc2", 64'(beat_count_s), 64'd2);
        check_value("basic_ov_b2", 64'(out_valid_s), 64'd0);
        beat(16'h4000, 16'h4000, 16'hFFFF, 16'h0001);
        check_value("basic_bc0", 64'(beat_count_s), 64'd0);
        check_value("basic_ov", 64'(out_valid_s), 64'd1);
        check_value("basic_data", 64'(out_data_s), 64'h0000_0000_FFFF_3000);
        step();
        check_value("basic_ov_taken", 64'(out_valid_s), 64'd0);

        // back-to-back windows at one beat per cycle
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) set_ops(16'h4000, 16'h4000, 16'h0000, 16'h0000);
            else       set_ops(16'h0100, 16'h0100, 16'h0000, 16'h0000);
            check_value("b2b_in_ready", 64'(in_ready_s), 64'd1);
            step();
            if (i == 2) check_value("b2b_data_w1", 64'(out_data_s), 64'h0000_3000);
            if (i == 3) check_value("b2b_ov_drop", 64'(out_valid_s), 64'd0);
            if (i == 5) begin
                check_value("b2b_ov_w2", 64'(out_valid_s), 64'd1);
                check_value("b2b_data_w2", 64'(out_data_s), 64'h0000_0003);
            end
        end
        in_valid = 1'b0;
        step();

        // positive saturation / truncation
        for (int i = 0; i < 3; i++) beat(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000);
        check_value("possat_data", 64'(out_data_s), 64'h0000_7FFF);
        check_value("postrunc_data", 64'(out_data_t), 64'h0000_BFFD);
        step();

        // negative saturation / truncation
        for (int i = 0; i < 3; i++) beat(16'h8000, 16'h7FFF, 16'h0000, 16'h0000);
        check_value("negsat_data", 64'(out_data_s), 64'h0000_8000);
        check_value("negtrunc_data", 64'(out_data_t), 64'h0000_4001);
        step();

        // backpressure
        for (int i = 0; i < 3; i++) beat(16'h4000, 16'h4000, 16'h0100, 16'h0100);
        check_value("bp_w1_data", 64'(out_data_s), 64'h0003_3000);
        step();
        check_value("bp_w1_taken", 64'(out_valid_s), 64'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_ops(16'h4000, 16'h4000, 16'hFFFF, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            check_value("bp_w2_in_ready", 64'(in_ready_s), 64'd1);
            step();
        end
        check_value("bp_w2_ov", 64'(out_valid_s), 64'd1);
        check_value("bp_w2_data", 64'(out_data_s), 64'hFFFF_3000);
        set_ops(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        check_value("bp_stall_in_ready", 64'(in_ready_s), 64'd0);
        step();
        step();
        check_value("bp_stall_bc", 64'(beat_count_s), 64'd0);
        check_value("bp_stall_ov", 64'(out_valid_s), 64'd1);
        check_value("bp_stall_data", 64'(out_data_s), 64'hFFFF_3000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check_value("bp_release_in_ready", 64'(in_ready_s), 64'd1);
        step();
        check_value("bp_release_ov", 64'(out_valid_s), 64'd0);

        // clear restarts the window with the coincident beat
        beat(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        beat(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        clear = 1'b1;
        beat(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        clear = 1'b0;
        check_value("clr_bc1", 64'(beat_count_s), 64'd1);
        check_value("clr_ov_b3", 64'(out_valid_s), 64'd0);
        beat(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        check_value("clr_bc2", 64'(beat_count_s), 64'd2);
        check_value("clr_ov_b4", 64'(out_valid_s), 64'd0);
        out_ready = 1'b0;
        beat(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        check_value("clr_ov_b5", 64'(out_valid_s), 64'd1);
        check_value("clr_data", 64'(out_data_s), 64'h0000_3000);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_value("clr_pending_ov", 64'(out_valid_s), 64'd1);
        check_value("clr_pending_data", 64'(out_data_s), 64'h0000_3000);
        out_ready = 1'b1;
        step();
        check_value("clr_pending_taken", 64'(out_valid_s), 64'd0);

        // clear with no beat mid-window
        beat(16'h0100, 16'h0100, 16'h0000, 16'h0000);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_value("clr_idle_bc", 64'(beat_count_s), 64'd0);
        for (int i = 0; i < 3; i++) beat(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        check_value("clr_idle_data", 64'(out_data_s), 64'h0000_3000);
        step();

        // asynchronous reset mid-window
        beat(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        beat(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        check_value("arst_pre_bc", 64'(beat_count_s), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check_value("arst_bc", 64'(beat_count_s), 64'd0);
        check_value("arst_ov", 64'(out_valid_s), 64'd0);
        check_value("arst_data", 64'(out_data_s), 64'd0);
        step();
        reset_n = 1'b1;
        beat(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        check_value("arst_new_bc1", 64'(beat_count_s), 64'd1);
        beat(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        check_value("arst_new_ov_b2", 64'(out_valid_s), 64'd0);
        beat(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        check_value("arst_new_ov", 64'(out_valid_s), 64'd1);
        check_value("arst_new_data", 64'(out_data_s), 64'h0000_3000);
        step();

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
